// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: decoded ALU op codes and the
// divider FSM state encoding.
package div_unit_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement: passes the value through, or negates it when
// neg is set. Used for operand magnitudes and for the final sign fix-up.
module div_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    // Negate on request; the most negative value maps onto itself.
    always_comb begin
        if (neg) begin
            res = ~val + {{(W-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: radix-2 restoring division,
// one quotient bit per cycle, quotient on lo_o and remainder on hi_o.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [7:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              annul_i,
    output logic              stall_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int RQ_W = 2 * DATA_W + 1;

    div_state_e        state_r, state_nxt_s;
    logic [5:0]        cnt_r;
    logic [RQ_W-1:0]   rq_r, rq_shift_s, rq_step_s;
    logic [DATA_W+1:0] trial_s;
    logic [DATA_W-1:0] divisor_r, abs_a_s, abs_b_s, quo_fix_s, rem_fix_s;
    logic              sign_a_r, sign_b_r, signed_r;
    logic              op_valid_s, op_signed_s, accept_s, last_s, div_zero_s;

    assign op_signed_s = (op_i == EXE_DIV_OP);
    assign op_valid_s  = (op_i == EXE_DIV_OP) || (op_i == EXE_DIVU_OP);
    assign accept_s    = (state_r == DIV_IDLE) && start_i && !annul_i && op_valid_s;
    assign div_zero_s  = (src_b_i == {DATA_W{1'b0}});
    assign last_s      = (state_r == DIV_BUSY) && (cnt_r == 6'(DATA_W - 1));

    div_abs #(.W(DATA_W)) u_abs_a (.val(src_a_i), .neg(op_signed_s & src_a_i[DATA_W-1]), .res(abs_a_s));
    div_abs #(.W(DATA_W)) u_abs_b (.val(src_b_i), .neg(op_signed_s & src_b_i[DATA_W-1]), .res(abs_b_s));
    div_abs #(.W(DATA_W)) u_fix_q (.val(rq_step_s[DATA_W-1:0]),
                                   .neg(signed_r & (sign_a_r ^ sign_b_r)), .res(quo_fix_s));
    div_abs #(.W(DATA_W)) u_fix_r (.val(rq_step_s[2*DATA_W-1:DATA_W]),
                                   .neg(signed_r & sign_a_r), .res(rem_fix_s));

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    always_comb begin
        rq_shift_s = rq_r << 1;
        trial_s    = {1'b0, rq_shift_s[RQ_W-1:DATA_W]} - {2'b00, divisor_r};
        if (!trial_s[DATA_W+1]) begin
            rq_step_s = {trial_s[DATA_W:0], rq_shift_s[DATA_W-1:1], 1'b1};
        end else begin
            rq_step_s = rq_shift_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a flush overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (annul_i) begin
            state_nxt_s = DIV_IDLE;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = div_zero_s ? DIV_DONE : DIV_BUSY;
                    end else begin
                        state_nxt_s = DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    if (last_s) begin
                        state_nxt_s = DIV_DONE;
                    end else begin
                        state_nxt_s = DIV_BUSY;
                    end
                end
                DIV_DONE: state_nxt_s = DIV_IDLE;
                default:  state_nxt_s = DIV_IDLE;
            endcase
        end
    end

    // Operand latch at accept, then iterate the shift register and counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rq_r      <= {RQ_W{1'b0}};
            divisor_r <= {DATA_W{1'b0}};
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            signed_r  <= 1'b0;
            cnt_r     <= 6'd0;
        end else if (accept_s) begin
            rq_r      <= {{(DATA_W+1){1'b0}}, abs_a_s};
            divisor_r <= abs_b_s;
            sign_a_r  <= src_a_i[DATA_W-1];
            sign_b_r  <= src_b_i[DATA_W-1];
            signed_r  <= op_signed_s;
            cnt_r     <= 6'd0;
        end else if (state_r == DIV_BUSY) begin
            rq_r  <= rq_step_s;
            cnt_r <= cnt_r + 6'd1;
        end else begin
            rq_r  <= rq_r;
            cnt_r <= cnt_r;
        end
    end

    // Result registers change only on entry to DONE, never on a flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_o <= {DATA_W{1'b0}};
            lo_o <= {DATA_W{1'b0}};
        end else if (accept_s && div_zero_s) begin
            hi_o <= src_a_i;
            lo_o <= {DATA_W{1'b1}};
        end else if (last_s && !annul_i) begin
            hi_o <= rem_fix_s;
            lo_o <= quo_fix_s;
        end else begin
            hi_o <= hi_o;
            lo_o <= lo_o;
        end
    end

    // Handshake: stall while accepting or iterating, pulse ready in DONE.
    always_comb begin
        stall_o = 1'b0;
        ready_o = 1'b0;
        if (resetn) begin
            stall_o = accept_s || (state_r == DIV_BUSY);
            ready_o = (state_r == DIV_DONE) && !annul_i;
        end else begin
            stall_o = 1'b0;
            ready_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a driver issues divides and queues expected
// results from an arithmetic reference; a monitor checks each ready_o pulse.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic [7:0]  op_i;
    logic [31:0] src_a_i, src_b_i;
    logic        annul_i;
    logic        stall_o, ready_o;
    logic [31:0] hi_o, lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_hi = 32'd0, last_lo = 32'd0;

    div_unit #(.DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .annul_i(annul_i),
        .stall_o(stall_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (op == EXE_DIVU_OP) begin
            lo = a / b;
            hi = a % b;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    // Monitor: every expected ready cycle must show ready_o with matching data.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            chk("ready_pulse", 32'(ready_o), 32'd1);
            chk("lo", lo_o, sbq[0].lo);
            chk("hi", hi_o, sbq[0].hi);
            void'(sbq.pop_front());
        end else if (ready_o) begin
            chk("unexpected_ready", 32'(ready_o), 32'd0);
        end
        if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            chk("missed_ready", 32'd0, 32'd1);
            void'(sbq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issue one divide, hold it while stalled, scrambling operands after accept.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        lat     = (b == 32'd0) ? 1 : 33;
        start_i = 1'b1;
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        model(op, a, b, e.hi, e.lo);
        e.cyc   = cyc + lat;
        sbq.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk("stall", 32'(stall_o), 32'(k < lat));
            tick();
            src_a_i = $urandom;
            src_b_i = $urandom;
        end
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0:       pick = 32'd0;
            1:       pick = 32'($urandom_range(1, 15));
            2:       pick = 32'hFFFF_FFFF;
            3:       pick = 32'h8000_0000;
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        resetn  = 1'b0;
        start_i = 1'b0;
        op_i    = 8'h00;
        src_a_i = 32'd0;
        src_b_i = 32'd0;
        annul_i = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        tick();
        resetn = 1'b1;
        idle(2);

        run_div(EXE_DIVU_OP, 32'd100, 32'd7);
        idle(2);
        chk("hold_lo", lo_o, last_lo);
        chk("hold_hi", hi_o, last_hi);
        run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
        run_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE);
        run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1);
        run_div(EXE_DIVU_OP, 32'd5, 32'd0);
        run_div(EXE_DIV_OP, 32'h8000_0000, 32'd0);
        idle(1);

        // Non-divide op with start high must be ignored.
        start_i = 1'b1;
        op_i    = 8'h00;
        src_a_i = 32'd10;
        src_b_i = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("badop_stall", 32'(stall_o), 32'd0);
            tick();
        end

        // Flush together with start in IDLE: no accept.
        op_i    = EXE_DIVU_OP;
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul_idle_stall", 32'(stall_o), 32'd0);
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("annul_idle_busy", 32'(stall_o), 32'd0);
        tick();

        // Flush at cycle 10 of DIVU 100/7.
        start_i = 1'b1;
        op_i    = EXE_DIVU_OP;
        src_a_i = 32'd100;
        src_b_i = 32'd7;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("pre_annul_stall", 32'(stall_o), 32'd1);
            tick();
        end
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul_cycle_stall", 32'(stall_o), 32'd1);
        tick();
        annul_i = 1'b0;
        start_i = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("post_annul_stall", 32'(stall_o), 32'd0);
            if (k == 29) begin
                chk("annul_keep_lo", lo_o, last_lo);
                chk("annul_keep_hi", hi_o, last_hi);
            end
            tick();
        end
        run_div(EXE_DIVU_OP, 32'd9, 32'd3);

        // Back-to-back issue.
        run_div(EXE_DIVU_OP, 32'd1000, 32'd33);
        run_div(EXE_DIV_OP, 32'hFFFF_FC18, 32'd33);
        run_div(EXE_DIVU_OP, 32'd0, 32'd9);
        idle(1);

        // Randomized divides with random gaps.
        for (int n = 0; n < 40; n++) begin
            run_div(($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP,
                    pick($urandom_range(0, 9)), pick($urandom_range(0, 9)));
            idle($urandom_range(0, 2));
        end

        // Reset pulse mid-BUSY with start still high.
        start_i = 1'b1;
        op_i    = EXE_DIVU_OP;
        src_a_i = 32'd12345;
        src_b_i = 32'd11;
        for (int k = 0; k < 6; k++) tick();
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd0);
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_lo", lo_o, 32'd0);
        tick();
        resetn  = 1'b1;
        start_i = 1'b0;
        for (int k = 0; k < 35; k++) tick();
        chk("postrst_lo", lo_o, 32'd0);
        chk("postrst_hi", hi_o, 32'd0);
        run_div(EXE_DIVU_OP, 32'd77, 32'd5);
        idle(3);
        chk("queue_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
